// File: rtl/popcount_match_pipe.sv
// Two-stage valid/ready popcount classifier: counts set bits, compares against K under a mode,
// and keeps a saturating mismatch counter. Optional lowest-set-bit index output under ONEHOT_INDEX_EN.
module popcount_match_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [CNT_W-1:0] in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_match,
`ifdef ONEHOT_INDEX_EN
    output logic [$clog2(WIDTH)-1:0] out_index,
`endif
    output logic [ERR_W-1:0] err_count,
    input  logic             err_clear
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    localparam logic [1:0] MODE_EXACT    = 2'b00;
    localparam logic [1:0] MODE_AT_MOST  = 2'b01;
    localparam logic [1:0] MODE_AT_LEAST = 2'b10;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    logic [1:0]       s1_mode_reg;
    logic [CNT_W-1:0] s1_k_reg;

    logic             out_valid_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_match_reg;
    logic [ERR_W-1:0] err_count_reg;

    logic             s2_can_load;
    logic [CNT_W-1:0] pop_count;
    logic             match_next;

    assign s2_can_load = out_ready | ~out_valid_reg;
    assign in_ready    = ~s1_valid_reg | s2_can_load;

    // Balanced adder tree; leaves beyond WIDTH are padded with zero.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
            localparam int NODES = LEAVES >> gi;
            logic [CNT_W-1:0] node [NODES];
            for (gj = 0; gj < NODES; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    if (gj < WIDTH) begin : g_bit
                        assign node[gj] = CNT_W'(s1_data_reg[gj]);
                    end else begin : g_pad
                        assign node[gj] = '0;
                    end
                end else begin : g_add
                    assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
                end
            end
        end
    endgenerate

    assign pop_count = g_lvl[LEVELS].node[0];

    always_comb begin
        match_next = 1'b0;
        case (s1_mode_reg)
            MODE_EXACT:    match_next = (pop_count == s1_k_reg);
            MODE_AT_MOST:  match_next = (pop_count <= s1_k_reg);
            MODE_AT_LEAST: match_next = (pop_count >= s1_k_reg);
            default:       match_next = (pop_count == '0) || (pop_count == s1_k_reg);
        endcase
    end

`ifdef ONEHOT_INDEX_EN
    localparam int IDX_W = $clog2(WIDTH);
    logic [IDX_W-1:0] low_index;
    logic [IDX_W-1:0] out_index_reg;

    // Scan from the top so the lowest set bit wins; a zero word leaves index 0.
    always_comb begin
        low_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (s1_data_reg[i]) begin
                low_index = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_index_reg <= '0;
        end else if (s2_can_load && s1_valid_reg) begin
            out_index_reg <= low_index;
        end
    end

    assign out_index = out_index_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_mode_reg   <= '0;
            s1_k_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_match_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_data_reg <= in_data;
                    s1_mode_reg <= in_mode;
                    s1_k_reg    <= in_k;
                end
            end

            if (s2_can_load) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_count_reg <= pop_count;
                    out_match_reg <= match_next;
                end
            end

            // Clear wins over a same-cycle mismatch delivery.
            if (err_clear) begin
                err_count_reg <= '0;
            end else if (out_valid_reg && out_ready && !out_match_reg && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + ERR_W'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_match = out_match_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_popcount_match_pipe.sv
// Bench for popcount_match_pipe: a WIDTH=4/ERR_W=2 instance and a WIDTH=16 instance,
// table-driven streams checked through per-instance scoreboards plus hand-written corner sequences.
module tb_popcount_match_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance a: WIDTH=4, ERR_W=2
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_match, a_err_clear;
    logic [3:0] a_in_data;
    logic [1:0] a_in_mode;
    logic [2:0] a_in_k, a_out_count;
    logic [1:0] a_err_count;
`ifdef ONEHOT_INDEX_EN
    logic [1:0] a_out_index;
`endif

    // Instance b: WIDTH=16, ERR_W=8
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_match, b_err_clear;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_k, b_out_count;
    logic [7:0]  b_err_count;
`ifdef ONEHOT_INDEX_EN
    logic [3:0]  b_out_index;
`endif

    popcount_match_pipe #(.WIDTH(4), .ERR_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_k(a_in_k),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_count(a_out_count), .out_match(a_out_match),
`ifdef ONEHOT_INDEX_EN
        .out_index(a_out_index),
`endif
        .err_count(a_err_count), .err_clear(a_err_clear)
    );

    popcount_match_pipe #(.WIDTH(16), .ERR_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_k(b_in_k),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_count(b_out_count), .out_match(b_out_match),
`ifdef ONEHOT_INDEX_EN
        .out_index(b_out_index),
`endif
        .err_count(b_err_count), .err_clear(b_err_clear)
    );

    typedef struct {
        logic [4:0] cnt;
        logic       match;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [4:0]  k;
        logic [4:0]  cnt;
        logic        match;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] model_idx(input logic [15:0] d);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (d[i]) r = 4'(i);
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [4:0] cnt, input logic match, input logic [15:0] d);
        exp_t e;
        e.cnt   = cnt;
        e.match = match;
        e.idx   = model_idx(d);
        return e;
    endfunction

    // Scoreboards: a transfer seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_output", 1, 0);
            end else begin
                e = qa.pop_front();
                $display("[TB] a out count=%0d match=%0d (exp %0d/%0d)", a_out_count, a_out_match, e.cnt, e.match);
                check("a_count", 32'(a_out_count), 32'(e.cnt));
                check("a_match", 32'(a_out_match), 32'(e.match));
`ifdef ONEHOT_INDEX_EN
                check("a_index", 32'(a_out_index), 32'(e.idx));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_output", 1, 0);
            end else begin
                e = qb.pop_front();
                $display("[TB] b out count=%0d match=%0d (exp %0d/%0d)", b_out_count, b_out_match, e.cnt, e.match);
                check("b_count", 32'(b_out_count), 32'(e.cnt));
                check("b_match", 32'(b_out_match), 32'(e.match));
`ifdef ONEHOT_INDEX_EN
                check("b_index", 32'(b_out_index), 32'(e.idx));
`endif
            end
        end
    end

    // Offer one word, wait (bounded) for in_ready, record expectation, return 1 time unit after the accepting edge.
    task automatic put_a(input logic [3:0] d, input logic [1:0] m, input logic [2:0] k, input exp_t e, input bit track);
        bit got;
        got = 1'b0;
        a_in_data = d; a_in_mode = m; a_in_k = k; a_in_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (a_in_ready) begin got = 1'b1; break; end
        end
        check("a_in_ready_wait", 32'(got), 1);
        if (got && track) qa.push_back(e);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic put_b(input logic [15:0] d, input logic [1:0] m, input logic [4:0] k, input exp_t e, input bit track);
        bit got;
        got = 1'b0;
        b_in_data = d; b_in_mode = m; b_in_k = k; b_in_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (b_in_ready) begin got = 1'b1; break; end
        end
        check("b_in_ready_wait", 32'(got), 1);
        if (got && track) qb.push_back(e);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va[5];
        vec_t vb[13];
        int   exp_err;
        int   sat_exp;

        va[0] = '{16'h0000, 2'b00, 5'd1, 5'd0, 1'b0};
        va[1] = '{16'h0001, 2'b00, 5'd1, 5'd1, 1'b1};
        va[2] = '{16'h0006, 2'b00, 5'd1, 5'd2, 1'b0};
        va[3] = '{16'h0008, 2'b00, 5'd1, 5'd1, 1'b1};
        va[4] = '{16'h000F, 2'b00, 5'd1, 5'd4, 1'b0};

        vb[0]  = '{16'h0007, 2'b01, 5'd3,  5'd3,  1'b1};
        vb[1]  = '{16'h000F, 2'b01, 5'd3,  5'd4,  1'b0};
        vb[2]  = '{16'hFFFF, 2'b10, 5'd16, 5'd16, 1'b1};
        vb[3]  = '{16'h0000, 2'b11, 5'd2,  5'd0,  1'b1};
        vb[4]  = '{16'h0101, 2'b11, 5'd2,  5'd2,  1'b1};
        vb[5]  = '{16'h0001, 2'b11, 5'd2,  5'd1,  1'b0};
        vb[6]  = '{16'hFFFF, 2'b00, 5'd20, 5'd16, 1'b0};
        vb[7]  = '{16'hFFFF, 2'b01, 5'd31, 5'd16, 1'b1};
        vb[8]  = '{16'hFFFF, 2'b10, 5'd17, 5'd16, 1'b0};
        vb[9]  = '{16'h0100, 2'b00, 5'd1,  5'd1,  1'b1};
        vb[10] = '{16'h0020, 2'b00, 5'd1,  5'd1,  1'b1};
        vb[11] = '{16'h0000, 2'b00, 5'd0,  5'd0,  1'b1};
        vb[12] = '{16'h8001, 2'b10, 5'd2,  5'd2,  1'b1};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_in_k = '0; a_out_ready = 1; a_err_clear = 0;
        b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_in_k = '0; b_out_ready = 1; b_err_clear = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("a_rst_in_ready", 32'(a_in_ready), 1);
        check("a_rst_out_valid", 32'(a_out_valid), 0);
        check("a_rst_out_count", 32'(a_out_count), 0);
        check("a_rst_out_match", 32'(a_out_match), 0);
        check("a_rst_err_count", 32'(a_err_count), 0);
        check("b_rst_in_ready", 32'(b_in_ready), 1);
        check("b_rst_out_valid", 32'(b_out_valid), 0);
        check("b_rst_out_count", 32'(b_out_count), 0);
        check("b_rst_out_match", 32'(b_out_match), 0);
        check("b_rst_err_count", 32'(b_err_count), 0);
        @(posedge clk); #1;

        // Legacy exactly-one-hot stream on the 4-bit instance
        exp_err = 0;
        for (int i = 0; i < 5; i++) begin
            put_a(va[i].d[3:0], va[i].m, va[i].k[2:0], mk_exp(va[i].cnt, va[i].match, va[i].d), 1'b1);
            if (!va[i].match) exp_err++;
        end
        repeat (4) @(posedge clk); #1;
        check("a_legacy_err_count", 32'(a_err_count), 32'(exp_err));
        check("a_legacy_drained", 32'(qa.size()), 0);

        // Saturation of a 2-bit error counter
        a_err_clear = 1'b1;
        @(posedge clk); #1;
        a_err_clear = 1'b0;
        check("a_err_clear_idle", 32'(a_err_count), 0);
        for (int j = 0; j < 5; j++) begin
            put_a(4'b0000, 2'b00, 3'd1, mk_exp(5'd0, 1'b0, 16'h0000), 1'b1);
            repeat (3) @(posedge clk); #1;
            sat_exp = (j + 1 > 3) ? 3 : j + 1;
            check("a_err_saturate", 32'(a_err_count), 32'(sat_exp));
        end
        put_a(4'b0000, 2'b00, 3'd1, mk_exp(5'd0, 1'b0, 16'h0000), 1'b1);
        check("a_latency_stage1", 32'(a_out_valid), 0);
        @(posedge clk); #1;
        check("a_latency_stage2", 32'(a_out_valid), 1);
        a_err_clear = 1'b1;
        @(posedge clk); #1;
        a_err_clear = 1'b0;
        check("a_err_clear_priority", 32'(a_err_count), 0);
        check("a_sat_drained", 32'(qa.size()), 0);

        // Mode/threshold table on the 16-bit instance
        exp_err = 0;
        for (int i = 0; i < 13; i++) begin
            put_b(vb[i].d, vb[i].m, vb[i].k, mk_exp(vb[i].cnt, vb[i].match, vb[i].d), 1'b1);
            if (!vb[i].match) exp_err++;
        end
        repeat (4) @(posedge clk); #1;
        check("b_table_err_count", 32'(b_err_count), 32'(exp_err));
        check("b_table_drained", 32'(qb.size()), 0);

        // Backpressure: fill both stages, hold, then release
        b_out_ready = 1'b0;
        put_b(16'h0003, 2'b00, 5'd2, mk_exp(5'd2, 1'b1, 16'h0003), 1'b1);
        put_b(16'h00F0, 2'b01, 5'd3, mk_exp(5'd4, 1'b0, 16'h00F0), 1'b1);
        b_in_data = 16'h7FFF; b_in_mode = 2'b10; b_in_k = 5'd15; b_in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("b_bp_in_ready", 32'(b_in_ready), 0);
            check("b_bp_out_valid", 32'(b_out_valid), 1);
            check("b_bp_hold_count", 32'(b_out_count), 2);
            check("b_bp_hold_match", 32'(b_out_match), 1);
        end
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        put_b(16'h7FFF, 2'b10, 5'd15, mk_exp(5'd15, 1'b1, 16'h7FFF), 1'b1);
        repeat (4) @(posedge clk); #1;
        check("b_bp_drained", 32'(qb.size()), 0);
        check("b_bp_err_count", 32'(b_err_count), 32'(exp_err + 1));

        // Reset with both stages full
        b_out_ready = 1'b0;
        put_b(16'h0001, 2'b00, 5'd1, mk_exp(5'd1, 1'b1, 16'h0001), 1'b0);
        put_b(16'h0003, 2'b00, 5'd1, mk_exp(5'd2, 1'b0, 16'h0003), 1'b0);
        check("b_prerst_out_valid", 32'(b_out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("b_midrst_out_valid", 32'(b_out_valid), 0);
        check("b_midrst_in_ready", 32'(b_in_ready), 1);
        check("b_midrst_err_count", 32'(b_err_count), 0);
        check("a_midrst_err_count", 32'(a_err_count), 0);
        b_out_ready = 1'b1;
        put_b(16'h0020, 2'b00, 5'd1, mk_exp(5'd1, 1'b1, 16'h0020), 1'b1);
        check("b_postrst_lat_stage1", 32'(b_out_valid), 0);
        @(posedge clk); #1;
        check("b_postrst_lat_stage2", 32'(b_out_valid), 1);
        check("b_postrst_count", 32'(b_out_count), 1);
        repeat (3) @(posedge clk); #1;
        check("b_postrst_drained", 32'(qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
